// File: rtl/bcd_to_binary.sv
// Purpose: sequential packed-BCD to unsigned-binary converter (reverse double-dabble).
// Latency: BIN_W cycles from accepting edge to done for valid input, 1 cycle for a bad digit.
// Backpressure: none queued; start is only honoured in IDLE and dropped while busy.
module bcd_to_binary #(
  parameter int DIGITS = 9,
  parameter int BIN_W  = 30
) (
  input  logic                Clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BCD_W-1:0]    bcd_reg;
  logic [BCD_W-1:0]    bcd_nxt;
  logic [BCD_W-1:0]    bcd_sh;
  logic [BCD_W-1:0]    bcd_fix;
  logic [BIN_W-1:0]    bin_reg;
  logic [BIN_W-1:0]    bin_nxt;
  logic [BIN_W-1:0]    bin_sh;
  logic [BIN_W-1:0]    bin_out_nxt;
  logic [ITER_W-1:0]   iter;
  logic [ITER_W-1:0]   iter_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                err_nxt;
  logic                in_bad;
  logic                last_iter;

  // Flag a request carrying any digit outside 0..9.
  always_comb begin
    in_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift the pair right, then fix each digit independently.
  always_comb begin
    {bcd_sh, bin_sh} = {bcd_reg, bin_reg} >> 1;
    bcd_fix = bcd_sh;
    for (int d = 0; d < DIGITS; d++) begin
      // A digit that received the shifted-in MSB carries a half-ten (8 instead of 5); take 3 off.
      if (bcd_sh[4*d +: 4] >= 4'd8) bcd_fix[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
    end
  end

  assign last_iter = (iter == LAST_ITER);

  // State, datapath and registered outputs; reset overrides everything including start.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      iter    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state   <= state_nxt;
      bcd_reg <= bcd_nxt;
      bin_reg <= bin_nxt;
      iter    <= iter_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      bin_out <= bin_out_nxt;
    end
  end

  // Next-state selection: only a clean request leaves IDLE; the last iteration returns.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && !in_bad) state_nxt = SHIFT;
      SHIFT: if (last_iter)        state_nxt = IDLE;
    endcase
  end

  // Next values of datapath and outputs; done defaults low so it is a single-cycle pulse.
  always_comb begin
    bcd_nxt     = bcd_reg;
    bin_nxt     = bin_reg;
    iter_nxt    = iter;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    bin_out_nxt = bin_out;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            // Bad digit completes immediately with a zero result and no SHIFT phase.
            bin_out_nxt = '0;
            err_nxt     = 1'b1;
            done_nxt    = 1'b1;
          end else begin
            bcd_nxt  = bcd_in;
            bin_nxt  = '0;
            iter_nxt = '0;
            busy_nxt = 1'b1;
            err_nxt  = 1'b0;
          end
        end
      end
      SHIFT: begin
        bcd_nxt  = bcd_fix;
        bin_nxt  = bin_sh;
        iter_nxt = iter + 1'b1;
        if (last_iter) begin
          bin_out_nxt = bin_sh;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          err_nxt     = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: directed scenarios plus random conversions against a decimal reference.
// Expected results come from plain base-10 arithmetic on the input digits.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_to_binary;

  localparam int DIGITS = 9;
  localparam int BIN_W  = 30;

  logic                Clk;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic                err;
  logic [BIN_W-1:0]    bin_out;

  int checks = 0;
  int errors = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .Clk     (Clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal value of the digits; a digit above 9 makes the request bad with expected result 0.
  function automatic void ref_model(input logic [4*DIGITS-1:0] b,
                                    output longint unsigned v, output bit bad);
    v   = 0;
    bad = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      int dig;
      dig = int'(b[4*d +: 4]);
      if (dig > 9) bad = 1'b1;
      v = v * 10 + longint'(dig);
    end
    if (bad) v = 0;
  endfunction

  // Advance until done, bounded; also note whether busy ever differed from exp_busy.
  task automatic wait_done(input bit exp_busy, output int idx, output bit busy_ok);
    idx     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && idx < 40) begin
      if (busy !== exp_busy) busy_ok = 1'b0;
      @(negedge Clk);
      idx++;
    end
  endtask

  task automatic run_conv(input logic [4*DIGITS-1:0] b, input string name);
    longint unsigned  v;
    bit               bad;
    int               idx;
    int               exp_idx;
    bit               busy_ok;
    logic [BIN_W-1:0] exp_bin;
    ref_model(b, v, bad);
    exp_bin = v[BIN_W-1:0];
    exp_idx = bad ? 0 : BIN_W;
    @(negedge Clk);
    start  = 1'b1;
    bcd_in = b;
    @(negedge Clk);
    start  = 1'b0;
    bcd_in = (4*DIGITS)'({$urandom(), $urandom()});
    wait_done(!bad, idx, busy_ok);
    checks++;
    if (idx !== exp_idx) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, idx, exp_idx);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_during: busy not %0d throughout", name, !bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    checks++;
    if (bin_out !== exp_bin) begin
      errors++;
      $display("FAIL %s bin_out: got %0d expected %0d", name, bin_out, exp_bin);
    end
    checks++;
    if (err !== bad) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, bad);
    end
    if (!bad) begin
      checks++;
      if (dut.bcd_reg !== '0) begin
        errors++;
        $display("FAIL %s bcd_reg_zero: got %h expected 0", name, dut.bcd_reg);
      end
    end
    @(negedge Clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 0 one cycle later", name, done);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b1;
    bcd_in = 36'h000000255;
    repeat (3) @(negedge Clk);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge Clk);
    checks++;
    if ({busy, done, err} !== 3'b000 || bin_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b bin_out=%0d expected all 0",
               busy, done, err, bin_out);
    end
  endtask

  task automatic test_directed();
    run_conv(36'h000000000, "zero");
    run_conv(36'h000000255, "d255");
    run_conv(36'h999999999, "max");
    run_conv(36'h00000A012, "bad_digit");
    run_conv(36'h000000001, "after_bad");
  endtask

  task automatic test_back_to_back();
    int idx;
    bit busy_ok;
    bit seen;
    @(negedge Clk);
    start  = 1'b1;
    bcd_in = 36'h000001234;
    @(negedge Clk);
    start  = 1'b0;
    idx    = 0;
    seen   = 1'b0;
    while (done !== 1'b1 && idx < 40) begin
      start  = (idx == 10);
      bcd_in = (idx == 10) ? 36'h000000007 : 36'h000001234;
      @(negedge Clk);
      idx++;
    end
    start = 1'b0;
    checks++;
    if (idx !== BIN_W) begin
      errors++;
      $display("FAIL ignore_start latency: got %0d expected %0d", idx, BIN_W);
    end
    checks++;
    if (bin_out !== 30'd1234) begin
      errors++;
      $display("FAIL ignore_start bin_out: got %0d expected 1234", bin_out);
    end
    // New request in the done cycle must be accepted.
    start  = 1'b1;
    bcd_in = 36'h000000007;
    @(negedge Clk);
    start = 1'b0;
    wait_done(1'b1, idx, busy_ok);
    checks++;
    if (idx !== BIN_W || !busy_ok) begin
      errors++;
      $display("FAIL back_to_back timing: got latency %0d busy_ok %b expected %0d 1",
               idx, busy_ok, BIN_W);
    end
    checks++;
    if (bin_out !== 30'd7) begin
      errors++;
      $display("FAIL back_to_back bin_out: got %0d expected 7", bin_out);
    end
    seen = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge Clk);
    start  = 1'b1;
    bcd_in = 36'h123456789;
    @(negedge Clk);
    start = 1'b0;
    repeat (15) @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bin_out !== '0) begin
      errors++;
      $display("FAIL reset_mid state: got busy=%b done=%b bin_out=%0d expected 0 0 0",
               busy, done, bin_out);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid aborted: got done/busy activity expected none");
    end
    run_conv(36'h000000042, "after_reset");
  endtask

  task automatic test_random();
    logic [4*DIGITS-1:0] b;
    for (int n = 0; n < 24; n++) begin
      for (int d = 0; d < DIGITS; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      run_conv(b, "random");
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
